// File: rtl/brick_wall_ctrl_pkg.sv
// Shared geometry defaults, brick index types and controller state for the brick wall.
package brick_pkg;
  localparam int ROWS       = 4;
  localparam int COLS       = 8;
  localparam int BRICK_W    = 32;
  localparam int BRICK_H    = 16;
  localparam int WALL_X     = 64;
  localparam int WALL_Y     = 48;
  localparam int NUM_BRICKS = ROWS * COLS;
  localparam int CNT_W      = $clog2(NUM_BRICKS + 1);
  localparam int ROW_W      = $clog2(ROWS);
  localparam int COL_W      = $clog2(COLS);

  typedef logic [ROW_W-1:0] row_t;
  typedef logic [COL_W-1:0] col_t;

  typedef enum logic {RUN, CLEARED} state_t;
endpackage

// File: rtl/brick_wall_ctrl_if.sv
// Bundle of frame/scan/hit inputs and draw/score outputs between the game and the wall controller.
interface brick_wall_if #(parameter int CNT_W = brick_pkg::CNT_W);
  logic             startOfFrame;
  logic             newLevel;
  logic [10:0]      pixelX;
  logic [10:0]      pixelY;
  logic             hitReq;
  logic [10:0]      hitX;
  logic [10:0]      hitY;
  logic [10:0]      offsetX;
  logic [10:0]      offsetY;
  logic             InsideRectangle;
  logic             brickHitPulse;
  logic [CNT_W-1:0] bricksLeft;
  logic             levelCleared;

  modport master (
    output startOfFrame, newLevel, pixelX, pixelY, hitReq, hitX, hitY,
    input  offsetX, offsetY, InsideRectangle, brickHitPulse, bricksLeft, levelCleared
  );
  modport slave (
    input  startOfFrame, newLevel, pixelX, pixelY, hitReq, hitX, hitY,
    output offsetX, offsetY, InsideRectangle, brickHitPulse, bricksLeft, levelCleared
  );
endinterface

// File: rtl/brick_wall_ctrl_locate.sv
// Combinational pixel -> wall membership, brick row/col and in-brick offset.
module brick_locate #(
  parameter int ROWS    = 4,
  parameter int COLS    = 8,
  parameter int BRICK_W = 32,
  parameter int BRICK_H = 16,
  parameter int WALL_X  = 64,
  parameter int WALL_Y  = 48
) (
  input  logic [10:0]              px_i,
  input  logic [10:0]              py_i,
  output logic                     in_wall_o,
  output logic [$clog2(ROWS)-1:0]  row_o,
  output logic [$clog2(COLS)-1:0]  col_o,
  output logic [10:0]              off_x_o,
  output logic [10:0]              off_y_o
);
  localparam int LOG_W = $clog2(BRICK_W);
  localparam int LOG_H = $clog2(BRICK_H);

  logic [11:0] x12, y12, rel_x, rel_y;

  // 12-bit compare keeps the upper bound from wrapping near the 11-bit limit.
  always_comb begin
    x12       = {1'b0, px_i};
    y12       = {1'b0, py_i};
    rel_x     = x12 - 12'(WALL_X);
    rel_y     = y12 - 12'(WALL_Y);
    in_wall_o = (x12 >= 12'(WALL_X)) && (x12 < 12'(WALL_X + COLS * BRICK_W)) &&
                (y12 >= 12'(WALL_Y)) && (y12 < 12'(WALL_Y + ROWS * BRICK_H));
    row_o     = '0;
    col_o     = '0;
    off_x_o   = '0;
    off_y_o   = '0;
    if (in_wall_o) begin
      row_o   = ($clog2(ROWS))'(rel_y >> LOG_H);
      col_o   = ($clog2(COLS))'(rel_x >> LOG_W);
      off_x_o = 11'(rel_x & 12'(BRICK_W - 1));
      off_y_o = 11'(rel_y & 12'(BRICK_H - 1));
    end
  end
endmodule

// File: rtl/brick_wall_ctrl.sv
// Brick wall alive/pending state, frame-deferred brick removal and one-cycle registered draw path.
module brick_wall_ctrl
  import brick_pkg::*;
#(
  parameter int ROWS    = brick_pkg::ROWS,
  parameter int COLS    = brick_pkg::COLS,
  parameter int BRICK_W = brick_pkg::BRICK_W,
  parameter int BRICK_H = brick_pkg::BRICK_H,
  parameter int WALL_X  = brick_pkg::WALL_X,
  parameter int WALL_Y  = brick_pkg::WALL_Y
) (
  input  logic         clk,
  input  logic         resetN,
  brick_wall_if.slave  bus
);
  localparam int NUM   = ROWS * COLS;
  localparam int CNT_W = $clog2(NUM + 1);
  localparam int IDX_W = $clog2(NUM);
  localparam int RW    = $clog2(ROWS);
  localparam int CW    = $clog2(COLS);

  logic              d_in, h_in;
  logic [RW-1:0]     d_row, h_row;
  logic [CW-1:0]     d_col, h_col;
  logic [10:0]       d_off_x, d_off_y, hit_unused_off_x, hit_unused_off_y;
  logic [IDX_W-1:0]  d_idx, h_idx;

  logic [NUM-1:0]    alive_q, alive_d, pending_q, pending_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  state_t            state_q, state_d;
  logic              pulse_q, pulse_d, inside_q, inside_d, accept;
  logic [10:0]       off_x_q, off_y_q;

  brick_locate #(.ROWS(ROWS), .COLS(COLS), .BRICK_W(BRICK_W), .BRICK_H(BRICK_H),
                 .WALL_X(WALL_X), .WALL_Y(WALL_Y)) u_draw_loc (
    .px_i(bus.pixelX), .py_i(bus.pixelY), .in_wall_o(d_in), .row_o(d_row),
    .col_o(d_col), .off_x_o(d_off_x), .off_y_o(d_off_y));

  brick_locate #(.ROWS(ROWS), .COLS(COLS), .BRICK_W(BRICK_W), .BRICK_H(BRICK_H),
                 .WALL_X(WALL_X), .WALL_Y(WALL_Y)) u_hit_loc (
    .px_i(bus.hitX), .py_i(bus.hitY), .in_wall_o(h_in), .row_o(h_row),
    .col_o(h_col), .off_x_o(hit_unused_off_x), .off_y_o(hit_unused_off_y));

  assign d_idx = IDX_W'(d_row * COLS + d_col);
  assign h_idx = IDX_W'(h_row * COLS + h_col);

  // A brick already pending cannot be hit again before it is committed.
  assign accept = (state_q == RUN) && bus.hitReq && !bus.newLevel && h_in &&
                  alive_q[h_idx] && !pending_q[h_idx];

  always_comb begin
    alive_d   = alive_q;
    pending_d = pending_q;
    cnt_d     = cnt_q;
    state_d   = state_q;
    pulse_d   = 1'b0;
    inside_d  = d_in && alive_q[d_idx] && (state_q == RUN);
    if (bus.newLevel) begin
      alive_d   = '1;
      pending_d = '0;
      cnt_d     = CNT_W'(NUM);
      state_d   = RUN;
    end else begin
      if (bus.startOfFrame) begin
        alive_d   = alive_q & ~pending_q;
        pending_d = '0;
        if (state_q == RUN && cnt_q == '0) state_d = CLEARED;
      end
      // Applied after the commit so a same-cycle hit survives into the next frame.
      if (accept) begin
        pending_d[h_idx] = 1'b1;
        cnt_d            = cnt_q - 1'b1;
        pulse_d          = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      alive_q   <= '1;
      pending_q <= '0;
      cnt_q     <= CNT_W'(NUM);
      state_q   <= RUN;
      pulse_q   <= 1'b0;
      inside_q  <= 1'b0;
      off_x_q   <= '0;
      off_y_q   <= '0;
    end else begin
      alive_q   <= alive_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      pulse_q   <= pulse_d;
      inside_q  <= inside_d;
      off_x_q   <= d_off_x;
      off_y_q   <= d_off_y;
    end
  end

  assign bus.offsetX         = off_x_q;
  assign bus.offsetY         = off_y_q;
  assign bus.InsideRectangle = inside_q;
  assign bus.brickHitPulse   = pulse_q;
  assign bus.bricksLeft      = cnt_q;
  assign bus.levelCleared    = (state_q == CLEARED);
endmodule
